alu_muldiv_seq: RTL and testbench

- Parametrised multi-cycle successor to the ALU control path. Decodes RV32M funct3 and sequences an iterative shift-add multiplier and restoring divider.
- Sits beside the single-cycle ALU in the EX stage. Receives a start pulse from the control path when ALUOp selects M-extension.
- Stalls the pipeline until the result is valid.
- Adds signed/unsigned operand handling, high-half products, divide-by-zero/overflow fast paths, and abort.

---
 rtl/alu_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, one bit per clock, with
// divide-by-zero and signed-overflow results produced without iterating.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          func_q, func_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic                signed_a, signed_b;
  logic                sign_a, sign_b;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                div_by_zero, div_ovf;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN-1:0]     div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, final_val;

  // Operand decode, per-step datapath and final sign correction
  always_comb begin
    accept      = (state_q == S_IDLE) && start && !flush;
    signed_a    = (func3 == 3'b001) || (func3 == 3'b010) ||
                  (func3 == 3'b100) || (func3 == 3'b110);
    signed_b    = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    sign_a      = signed_a && op_a[XLEN-1];
    sign_b      = signed_b && op_b[XLEN-1];
    mag_a       = sign_a ? -op_a : op_a;
    mag_b       = sign_b ? -op_b : op_b;
    div_by_zero = (op_b == '0);
    div_ovf     = !func3[0] && (op_a == MIN_NEG) && (op_b == '1);

    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, quo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[XLEN-1:0] - b_q;

    prod_fix = neg_res_q ? -prod_q : prod_q;
    quo_fix  = neg_res_q ? -quo_q : quo_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
    if (func_q[2]) begin
      final_val = func_q[1] ? rem_fix : quo_fix;
    end else begin
      final_val = (func_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state and next-datapath computation for the sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          func_d    = func3;
          a_d       = mag_a;
          b_d       = mag_b;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = '0;
          prod_d    = {{XLEN{1'b0}}, mag_b};
          rem_d     = '0;
          quo_d     = mag_a;
          if (func3[2]) begin
            if (div_by_zero) begin
              result_d = func3[1] ? op_a : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = func3[1] ? '0 : op_a;
              state_d  = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          result_d = final_val;
          state_d  = S_DONE;
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          result_d = final_val;
          state_d  = S_DONE;
        end else begin
          rem_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered status flags; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = accept | busy_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed testbench for alu_muldiv_seq with hand-computed RV32M results.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int compareCount = 0;
  int failCount = 0;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present a request off-edge, confirm stall, then let the acceptance edge pass
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    func3 = f;
    op_a  = a;
    op_b  = b;
    #1;
    checkOutput("stall on request", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    func3 = 3'b000;
    op_a  = 32'h0;
    op_b  = 32'h0;
  endtask

  // Full operation: request, wait for done with a bound, check result and pulse shape
  task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expected,
                       input bit isFast, input bit holdStartInDone);
    int edges;
    applyStimulus(f, a, b);
    if (isFast) begin
      checkOutput({tag, " fast busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " fast done"}, {31'd0, done}, 32'd1);
    end else begin
      checkOutput({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
      edges = 0;
      while (!done && edges < 100) begin
        @(posedge clk);
        #1;
        edges++;
      end
      checkOutput({tag, " latency"}, edges, 33);
    end
    checkOutput({tag, " result"}, result, expected);
    checkOutput({tag, " stall in done"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, " busy in done"}, {31'd0, busy}, 32'd0);
    if (holdStartInDone) begin
      start = 1'b1;
      func3 = 3'b101;
      op_a  = 32'd9;
      op_b  = 32'd0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    checkOutput({tag, " idle after done"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " result held"}, result, expected);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'b000;
    op_a  = 32'h0;
    op_b  = 32'h0;
    #12;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    runOp("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b1);
    runOp("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
    runOp("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runOp("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    runOp("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runOp("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
    runOp("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);

    // Abort a divide partway through; result must keep the REMU value
    applyStimulus(3'b100, 32'd1000, 32'd3);
    checkOutput("flush busy after accept", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busy dropped", {31'd0, busy}, 32'd0);
    checkOutput("flush no done", {31'd0, done}, 32'd0);
    checkOutput("flush result kept", result, 32'd2);
    runOp("DIVU after flush", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);

    runOp("DIVU by zero", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    runOp("REM by zero", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1, 1'b0);
    runOp("DIV overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a multiply
    applyStimulus(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset done", {31'd0, done}, 32'd0);
    checkOutput("async reset result", result, 32'h0);
    #2;
    rst_n = 1'b1;
    runOp("MUL after reset", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);

    runOp("REM overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  // Safety net so a stuck design still ends the run with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
